// File: rtl/wb_gpio_irq_pkg.sv
// Shared constants for the Wishbone GPIO block: register offsets, synchroniser
// depth bounds and the bus handshake states.
package wb_gpio_irq_pkg;

   localparam int GPIO_WIDTH_MIN  = 1;
   localparam int GPIO_WIDTH_MAX  = 32;
   localparam int SYNC_STAGES_MIN = 2;
   localparam int SYNC_STAGES_MAX = 3;

   // Register select, taken from wb_adr_i[4:2].
   typedef enum logic [2:0] {
      REG_DATA_IN  = 3'd0,
      REG_DATA_OUT = 3'd1,
      REG_DIR      = 3'd2,
      REG_OUT_SET  = 3'd3,
      REG_OUT_CLR  = 3'd4,
      REG_IRQ_EN   = 3'd5,
      REG_IRQ_POL  = 3'd6,
      REG_IRQ_STAT = 3'd7
   } reg_addr_e;

   // IDLE accepts a strobe; ACK is the single cycle the ack flop is high.
   typedef enum logic {
      BUS_IDLE = 1'b0,
      BUS_ACK  = 1'b1
   } bus_state_e;

endpackage

// File: rtl/gpio_edge_sync.sv
// Per-pin multi-stage input synchroniser plus a one-cycle history register,
// producing the synchronised value and its rising/falling edge strobes.
module gpio_edge_sync
   import wb_gpio_irq_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pad,
   output logic [WIDTH-1:0] sync,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
      $error("gpio_edge_sync: STAGES out of range");
   end

   logic [WIDTH-1:0] stage_q [STAGES];
   logic [WIDTH-1:0] prev_q;

   // NOTE: sequential state uses non-blocking assignments so every stage
   // samples its predecessor's pre-edge value; blocking would collapse the chain.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < STAGES; s++) stage_q[s] <= '0;
         prev_q <= '0;
      end else begin
         stage_q[0] <= pad;
         for (int s = 1; s < STAGES; s++) stage_q[s] <= stage_q[s-1];
         prev_q <= stage_q[STAGES-1];
      end
   end

   assign sync = stage_q[STAGES-1];
   assign rise = sync & ~prev_q;
   assign fall = ~sync & prev_q;

endmodule

// File: rtl/wb_gpio_irq.sv
// Wishbone-slave GPIO port with per-pin direction, atomic set/clear of outputs
// and per-pin edge interrupts combined into one level interrupt.
module wb_gpio_irq
   import wb_gpio_irq_pkg::*;
#(
   parameter int          GPIO_WIDTH  = 32,
   parameter logic [31:0] DIR_RESET   = '0,
   parameter logic [31:0] OUT_RESET   = '0,
   parameter int          SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           wb_adr_i,
   input  logic [31:0]           wb_dat_i,
   input  logic                  wb_we_i,
   input  logic                  wb_cyc_i,
   input  logic                  wb_stb_i,
   output logic                  wb_ack_o,
   output logic [31:0]           wb_dat_o,
   inout  wire  [GPIO_WIDTH-1:0] gpio_io,
   output logic                  irq_o
);

   if (GPIO_WIDTH < GPIO_WIDTH_MIN || GPIO_WIDTH > GPIO_WIDTH_MAX) begin : g_bad_width
      $error("wb_gpio_irq: GPIO_WIDTH out of range");
   end

   bus_state_e            state_q, state_d;
   logic                  access;
   logic                  wr;
   logic                  rd;
   reg_addr_e             reg_sel;
   logic [GPIO_WIDTH-1:0] wdata;
   logic [31:0]           rdata;
   logic [31:0]           dat_q;

   logic [GPIO_WIDTH-1:0] dir_q;
   logic [GPIO_WIDTH-1:0] out_q;
   logic [GPIO_WIDTH-1:0] en_q;
   logic [GPIO_WIDTH-1:0] pol_q;
   logic [GPIO_WIDTH-1:0] stat_q;
   logic [GPIO_WIDTH-1:0] stat_clr;

   logic [GPIO_WIDTH-1:0] pin_sync;
   logic [GPIO_WIDTH-1:0] pin_rise;
   logic [GPIO_WIDTH-1:0] pin_fall;
   logic [GPIO_WIDTH-1:0] evt;

   // Address bits outside the register select and data bits above the port
   // width are intentionally ignored.
   logic unused_adr;
   logic unused_wdata;
   assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};
   if (GPIO_WIDTH < 32) begin : g_wdata_hi
      assign unused_wdata = ^wb_dat_i[31:GPIO_WIDTH];
   end else begin : g_wdata_full
      assign unused_wdata = 1'b0;
   end

   // ---------------------------------------------------------------- bus FSM
   always_ff @(posedge clk) begin
      if (rst) state_q <= BUS_IDLE;
      else     state_q <= state_d;
   end

   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned, which would infer a latch.
   always_comb begin
      state_d = state_q;
      access  = 1'b0;
      case (state_q)
         BUS_IDLE: begin
            if (wb_stb_i && wb_cyc_i) begin
               access  = 1'b1;
               state_d = BUS_ACK;
            end
         end
         BUS_ACK:  state_d = BUS_IDLE;
         default:  state_d = BUS_IDLE;
      endcase
   end

   assign reg_sel  = reg_addr_e'(wb_adr_i[4:2]);
   assign wdata    = wb_dat_i[GPIO_WIDTH-1:0];
   assign wr       = access & wb_we_i;
   assign rd       = access & ~wb_we_i;
   assign wb_ack_o = (state_q == BUS_ACK) & wb_stb_i & wb_cyc_i;

   // ---------------------------------------------------------- register file
   always_ff @(posedge clk) begin
      if (rst) begin
         dir_q <= DIR_RESET[GPIO_WIDTH-1:0];
         out_q <= OUT_RESET[GPIO_WIDTH-1:0];
         en_q  <= '0;
         pol_q <= '0;
      end else if (wr) begin
         case (reg_sel)
            REG_DATA_OUT: out_q <= wdata;
            REG_DIR:      dir_q <= wdata;
            REG_OUT_SET:  out_q <= out_q | wdata;
            REG_OUT_CLR:  out_q <= out_q & ~wdata;
            REG_IRQ_EN:   en_q  <= wdata;
            REG_IRQ_POL:  pol_q <= wdata;
            default: ;
         endcase
      end
   end

   // A new event is OR-ed in after the clear so it survives a same-cycle W1C.
   assign stat_clr = (wr && reg_sel == REG_IRQ_STAT) ? wdata : '0;

   always_ff @(posedge clk) begin
      if (rst) stat_q <= '0;
      else     stat_q <= (stat_q & ~stat_clr) | evt;
   end

   always_comb begin
      rdata = '0;
      case (reg_sel)
         REG_DATA_IN:  rdata[GPIO_WIDTH-1:0] = pin_sync;
         REG_DATA_OUT: rdata[GPIO_WIDTH-1:0] = out_q;
         REG_DIR:      rdata[GPIO_WIDTH-1:0] = dir_q;
         REG_IRQ_EN:   rdata[GPIO_WIDTH-1:0] = en_q;
         REG_IRQ_POL:  rdata[GPIO_WIDTH-1:0] = pol_q;
         REG_IRQ_STAT: rdata[GPIO_WIDTH-1:0] = stat_q;
         default:      rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)     dat_q <= '0;
      else if (rd) dat_q <= rdata;
   end

   assign wb_dat_o = dat_q;

   // ------------------------------------------------------- pads and events
   for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pad
      assign gpio_io[i] = dir_q[i] ? out_q[i] : 1'bz;
   end

   gpio_edge_sync #(
      .WIDTH  (GPIO_WIDTH),
      .STAGES (SYNC_STAGES)
   ) u_edge_sync (
      .clk  (clk),
      .rst  (rst),
      .pad  (gpio_io),
      .sync (pin_sync),
      .rise (pin_rise),
      .fall (pin_fall)
   );

   // Pins configured as outputs never raise events.
   assign evt   = ~dir_q & ((pol_q & pin_rise) | (~pol_q & pin_fall));
   assign irq_o = |(stat_q & en_q);

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Randomised scoreboard bench for wb_gpio_irq against a transaction-level
// model of the register map and pin-edge interrupt rules.
module tb_wb_gpio_irq;
   import wb_gpio_irq_pkg::*;

   localparam int          W       = 8;
   localparam int          SS      = 2;
   localparam logic [31:0] DIR_RST = 32'h0000_0000;
   localparam logic [31:0] OUT_RST = 32'h0000_005A;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] wb_adr_i, wb_dat_i;
   logic        wb_we_i, wb_cyc_i, wb_stb_i;
   logic        wb_ack_o;
   logic [31:0] wb_dat_o;
   wire  [W-1:0] gpio_io;
   logic        irq_o;

   logic [W-1:0] tb_en, tb_val;

   for (genvar i = 0; i < W; i++) begin : g_tb_pad
      assign gpio_io[i] = tb_en[i] ? tb_val[i] : 1'bz;
   end

   always #5 clk = ~clk;

   wb_gpio_irq #(
      .GPIO_WIDTH  (W),
      .DIR_RESET   (DIR_RST),
      .OUT_RESET   (OUT_RST),
      .SYNC_STAGES (SS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wb_adr_i (wb_adr_i),
      .wb_dat_i (wb_dat_i),
      .wb_we_i  (wb_we_i),
      .wb_cyc_i (wb_cyc_i),
      .wb_stb_i (wb_stb_i),
      .wb_ack_o (wb_ack_o),
      .wb_dat_o (wb_dat_o),
      .gpio_io  (gpio_io),
      .irq_o    (irq_o)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------ reference model
   logic [W-1:0] m_dir, m_out, m_en, m_pol, m_stat, m_pad;

   function automatic logic [W-1:0] pad_now();
      return (m_dir & m_out) | (~m_dir & tb_val);
   endfunction

   // A settled change of an input pad in the enabled polarity sets its status.
   task automatic update_pad();
      logic [W-1:0] nxt, evt;
      nxt    = pad_now();
      evt    = (m_pad ^ nxt) & ~m_dir & ((m_pol & nxt) | (~m_pol & ~nxt));
      m_stat = m_stat | evt;
      m_pad  = nxt;
   endtask

   function automatic logic [31:0] model_read(input logic [2:0] a);
      case (a)
         3'd0:    return 32'(m_pad);
         3'd1:    return 32'(m_out);
         3'd2:    return 32'(m_dir);
         3'd5:    return 32'(m_en);
         3'd6:    return 32'(m_pol);
         3'd7:    return 32'(m_stat);
         default: return 32'h0;
      endcase
   endfunction

   // ------------------------------------------------------------ scoreboard
   typedef struct {
      logic [2:0]  addr;
      logic [31:0] exp;
   } rd_t;
   rd_t rd_q[$];

   always @(posedge clk) begin
      #2;
      if (wb_ack_o && !wb_we_i) begin
         if (rd_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_read_ack: got data 0x%08h expected no ack", wb_dat_o);
         end else begin
            rd_t e;
            e = rd_q.pop_front();
            check($sformatf("read_reg%0d", e.addr), wb_dat_o, e.exp);
         end
      end
   end

   // ------------------------------------------------------------- stimulus
   task automatic bus(input logic we, input logic [2:0] a, input logic [31:0] d);
      int cycles;
      @(negedge clk);
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = we;
      wb_adr_i = {27'h0, a, 2'b00};
      wb_dat_i = d;
      if (!we) rd_q.push_back('{a, model_read(a)});
      cycles = 0;
      do begin
         @(posedge clk);
         #1;
         cycles++;
      end while (!wb_ack_o && cycles < 8);
      check("ack_latency", 32'(cycles), 32'd1);
      @(negedge clk);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
   endtask

   task automatic settle();
      repeat (SS + 2) @(posedge clk);
      #1;
   endtask

   task automatic check_irq(input string name);
      check(name, 32'(irq_o), 32'(|(m_stat & m_en)));
   endtask

   // Writes without settling; the caller decides when to let events land.
   task automatic write_now(input logic [2:0] a, input logic [31:0] d);
      bus(1'b1, a, d);
      case (a)
         3'd1: m_out  = d[W-1:0];
         3'd3: m_out  = m_out | d[W-1:0];
         3'd4: m_out  = m_out & ~d[W-1:0];
         3'd5: m_en   = d[W-1:0];
         3'd6: m_pol  = d[W-1:0];
         3'd7: m_stat = m_stat & ~d[W-1:0];
         default: ;
      endcase
      update_pad();
   endtask

   task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
      write_now(a, d);
      settle();
   endtask

   // The bench releases pins before they become outputs and takes over newly
   // released pins at the value they already carry, so no pad edge results.
   task automatic set_dir(input logic [31:0] d);
      logic [W-1:0] nd;
      nd    = d[W-1:0];
      tb_en = tb_en & ~nd;
      bus(1'b1, 3'd2, d);
      tb_val = (tb_val & ~(m_dir & ~nd)) | (m_pad & m_dir & ~nd);
      m_dir  = nd;
      tb_en  = ~nd;
      update_pad();
      settle();
   endtask

   task automatic read_reg(input logic [2:0] a);
      bus(1'b0, a, 32'h0);
   endtask

   task automatic toggle(input logic [W-1:0] mask);
      @(negedge clk);
      tb_val = tb_val ^ (mask & ~m_dir);
      update_pad();
      settle();
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      wb_adr_i = '0;
      wb_dat_i = '0;
      wb_we_i  = 1'b0;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      tb_en    = '1;
      tb_val   = '0;
      m_dir    = DIR_RST[W-1:0];
      m_out    = OUT_RST[W-1:0];
      m_en     = '0;
      m_pol    = '0;
      m_stat   = '0;
      m_pad    = pad_now();

      repeat (3) @(posedge clk);
      #1;
      check("reset_ack", 32'(wb_ack_o), 32'd0);
      check("reset_dat", wb_dat_o, 32'h0);
      check("reset_irq", 32'(irq_o), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      settle();

      for (int a = 0; a < 8; a++) read_reg(3'(a));

      // Drive the low byte from DATA_OUT and read it back through the pads.
      set_dir(32'h0000_00FF);
      write_reg(3'd1, 32'h0000_00A5);
      check("pad_drive", 32'(gpio_io), 32'h0000_00A5);
      read_reg(3'd0);

      write_reg(3'd1, 32'h0000_00F0);
      write_reg(3'd3, 32'h0000_0003);
      read_reg(3'd1);
      write_reg(3'd4, 32'h0000_0030);
      read_reg(3'd1);
      read_reg(3'd0);
      write_reg(3'd7, 32'h0000_00FF);

      set_dir(32'h0);
      write_reg(3'd6, 32'h0000_0010);
      write_reg(3'd5, 32'h0000_0010);

      // Rising edge on pin 4: status and irq must appear exactly SS edges later.
      @(negedge clk);
      tb_val[4] = 1'b1;
      update_pad();
      repeat (SS) @(posedge clk);
      #1;
      check("irq_before_latency", 32'(irq_o), 32'd0);
      @(posedge clk);
      #1;
      check("irq_at_latency", 32'(irq_o), 32'd1);
      settle();
      read_reg(3'd7);
      toggle(8'h10);
      read_reg(3'd7);
      check_irq("irq_after_fall");
      write_now(3'd7, 32'h0000_0010);
      check("irq_cleared_next_cycle", 32'(irq_o), 32'd0);
      settle();

      // Status latches with the enable off; enabling afterwards raises irq.
      write_reg(3'd5, 32'h0);
      toggle(8'h10);
      check_irq("irq_masked");
      read_reg(3'd7);
      write_reg(3'd5, 32'h0000_0010);
      check_irq("irq_enabled_late");
      write_reg(3'd7, 32'h0000_0010);
      check_irq("irq_w1c");

      // W1C and a new rising event landing on the same edge: set wins.
      toggle(8'h10);
      @(negedge clk);
      tb_val[4] = 1'b1;
      @(negedge clk);
      write_now(3'd7, 32'h0000_0010);
      settle();
      read_reg(3'd7);
      check_irq("irq_set_wins");
      write_reg(3'd7, 32'h0000_00FF);

      set_dir(32'hFFFF_FFFF);
      read_reg(3'd2);

      for (int n = 0; n < 200; n++) begin
         int op;
         op = $urandom_range(0, 9);
         if (op <= 2) begin
            toggle(W'($urandom));
         end else if (op == 3) begin
            set_dir($urandom);
         end else if (op <= 7) begin
            int sel;
            logic [2:0] a;
            sel = $urandom_range(0, 5);
            case (sel)
               0: a = 3'd1;
               1: a = 3'd3;
               2: a = 3'd4;
               3: a = 3'd5;
               4: a = 3'd6;
               default: a = 3'd7;
            endcase
            write_reg(a, $urandom);
         end else begin
            read_reg(3'($urandom_range(0, 7)));
         end
         check_irq("irq_random");
      end

      repeat (4) @(posedge clk);
      #1;
      check("scoreboard_drained", 32'(rd_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_gpio_irq.md
Name: wb_gpio_irq

Overview:
- Parametrised Wishbone-slave GPIO port, 1 to 32 bits wide, with a per-pin tristate direction control.
- Adds features the fixed 8-bit GPIO lacks:
  - input synchroniser
  - atomic set and clear of output bits
  - per-pin edge interrupts, each with polarity, enable and write-1-to-clear status
  - single level interrupt output to the CPU interrupt controller
- Sits on the peripheral Wishbone bus beside the UART, timer and I2C slaves.

Parameters:
GPIO_WIDTH, 32, number of pins, legal range 1..32
DIR_RESET, 0, reset value of DIR (bit=1 means output)
OUT_RESET, 0, reset value of DATA_OUT
SYNC_STAGES, 2, input synchroniser flops per pin, legal range 2..3

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
wb_adr_i  in  32  byte address; register select is wb_adr_i[4:2]
wb_dat_i  in  32  write data
wb_we_i  in  1  write enable
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_ack_o  out  1  acknowledge
wb_dat_o  out  32  registered read data
gpio_io  inout  GPIO_WIDTH  pins
irq_o  out  1  level interrupt, active-high

Behaviour:
- Reset is rst, synchronous, active-high, on clk. Reset values:
  - DIR=DIR_RESET, DATA_OUT=OUT_RESET
  - IRQ_EN=0, IRQ_POL=0, IRQ_STAT=0
  - ack=0, wb_dat_o=0, irq_o=0
  - synchroniser and previous-value flops = 0
- Register map (wb_adr_i[4:2]):
  - 0 DATA_IN: RO, synchronised pin values
  - 1 DATA_OUT: RW
  - 2 DIR: RW
  - 3 OUT_SET: WO, DATA_OUT |= wdata; reads 0
  - 4 OUT_CLR: WO, DATA_OUT &= ~wdata; reads 0
  - 5 IRQ_EN: RW
  - 6 IRQ_POL: RW, 1=rising edge, 0=falling edge
  - 7 IRQ_STAT: R, write-1-to-clear
- Register bits [31:GPIO_WIDTH] read 0; writes to them are ignored.
- Bus handshake:
  - When stb&cyc&~ack, the access is performed and ack is set on the next clk.
  - ack clears on the following clk, so there is at least one idle cycle between acks. One access per strobe.
  - wb_ack_o = ack & wb_stb_i & wb_cyc_i. A strobe dropped early suppresses wb_ack_o.
  - Read data is registered in the same cycle ack is set, so read latency is 1 cycle.
  - wb_dat_o holds its last value when no read is in progress.
- Tristate: gpio_io[i] = DIR[i] ? DATA_OUT[i] : Z. The synchroniser always samples the pad, so DATA_IN reflects driven pins too.
- Synchroniser:
  - A pin change ahead of clk edge N appears in DATA_IN after edge N+SYNC_STAGES-1.
  - prev <= sync every clk.
- Edge detection:
  - rise[i] = sync[i] & ~prev[i]; fall[i] = ~sync[i] & prev[i].
  - evt[i] = ~DIR[i] & (IRQ_POL[i] ? rise[i] : fall[i]). Output pins never raise events.
  - Event at edge N+SYNC_STAGES sets IRQ_STAT[i] at that edge.
  - IRQ_STAT latches regardless of IRQ_EN; IRQ_EN only gates irq_o.
- irq_o = |(IRQ_STAT & IRQ_EN), combinational from flops only.
- Simultaneous events:
  - A W1C write and a new event on the same bit in the same cycle leave the bit set (set wins).
  - The DATA_OUT, OUT_SET and OUT_CLR addresses are exclusive per access, so no conflict arises.
- Changing IRQ_POL or DIR does not itself create an event. Events come only from sync/prev differences.
- Reset mid-transfer drops ack immediately on the next clk and loses the access. The master must retry.

Decomposition:
- Shared include file wb_gpio_defs.vh holds:
  - register offset constants REG_DATA_IN..REG_IRQ_STAT (3-bit)
  - the synchroniser depth bounds
- Sub-module gpio_edge_sync, parameterised by WIDTH and STAGES:
  - multi-stage synchroniser plus prev register
  - outputs sync, rise and fall vectors
- Top level holds the register file, bus FSM (IDLE / ACK via the ack flop), tristate generate loop and irq reduction.

Test Plan:
- Reset then read all 8 offsets -> DIR=DIR_RESET, DATA_OUT=OUT_RESET; 3, 4, 5, 6, 7 read 0; irq_o=0; every ack arrives exactly 1 cycle after stb.
- Write DIR=0x0000_00FF, DATA_OUT=0xA5 -> gpio_io[7:0]=0xA5, gpio_io[31:8]=Z; after SYNC_STAGES+1 cycles DATA_IN[7:0] reads 0xA5.
- DATA_OUT=0xF0; OUT_SET 0x03 -> 0xF3; OUT_CLR 0x30 -> 0xC3.
- DIR=0, IRQ_POL[4]=1, IRQ_EN[4]=1; drive pin4 0->1 -> IRQ_STAT=0x10 and irq_o=1 at edge N+SYNC_STAGES; pin4 1->0 sets nothing.
- Status set with IRQ_EN=0 -> irq_o stays 0; later IRQ_EN=0x10 -> irq_o=1; W1C 0x10 -> irq_o=0 next cycle.
- W1C of bit 4 in the same cycle as a new rising event on pin 4 -> IRQ_STAT[4] stays 1. With GPIO_WIDTH=8, write 0xFFFF_FFFF to DIR -> reads 0x0000_00FF.
